// File: rtl/agc_scaler.sv
// ---------------------------------------------------------------------------
// agc_scaler
//
// Purpose:
//   16-stage binary scaler driven by the timer's first stage FS01. Each
//   rising edge of FS01 advances a 16-bit counter whose bits are the scaler
//   stages FS02..FS17. For every update the block also produces per-stage
//   rise (F-pulse A) and fall (F-pulse B) strobes and a wrap strobe. An
//   optional watchdog flags a scaler failure when FS01 stops toggling.
//
// Configuration:
//   SCALER_FAIL_DETECT_EN  defined   -> idle watchdog built, SCAFAL active
//                          undefined -> no watchdog, SCAFAL tied low,
//                                       STALL_LIMIT ignored
//
// Parameters:
//   STALL_LIMIT  cycles without an FS01 rising edge before SCAFAL (2..65535)
//
// Ports:
//   SIM_CLK  in   1   system clock, rising-edge active
//   SIM_RST  in   1   asynchronous reset, active low
//   FS01     in   1   first scaler stage, synchronous to SIM_CLK
//   SCLR     in   1   synchronous scaler clear, active high
//   FS       out  16  scaler stages, FS[0]=FS02 .. FS[15]=FS17
//   FA_STB   out  16  one-cycle strobe per stage on 0->1
//   FB_STB   out  16  one-cycle strobe per stage on 1->0
//   WRAP     out  1   one-cycle strobe on 0xFFFF -> 0x0000
//   SCAFAL   out  1   scaler failure alarm (level)
// ---------------------------------------------------------------------------
module agc_scaler #(
    parameter int STALL_LIMIT = 64
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        FS01,
    input  logic        SCLR,
    output logic [15:0] FS,
    output logic [15:0] FA_STB,
    output logic [15:0] FB_STB,
    output logic        WRAP,
    output logic        SCAFAL
);

    logic        r_fs01Q;
    logic [15:0] r_cnt;
    logic [15:0] r_faStb;
    logic [15:0] r_fbStb;
    logic        r_wrap;
    logic        w_rise;
    logic [15:0] w_cntNext;

    assign w_rise    = FS01 & ~r_fs01Q;
    assign w_cntNext = r_cnt + 16'd1;

    // FS01 history. Resetting it to 1 means an FS01 that is already high
    // when reset releases is not mistaken for a rising edge.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_fs01Q <= 1'b1;
        end else begin
            r_fs01Q <= FS01;
        end
    end

    // Scaler counter and its strobes. The strobes are registered alongside
    // the count so they line up with the cycle in which FS shows the new
    // value. Clear wins over a coincident edge and suppresses all strobes.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_cnt   <= 16'h0000;
            r_faStb <= 16'h0000;
            r_fbStb <= 16'h0000;
            r_wrap  <= 1'b0;
        end else if (SCLR) begin
            r_cnt   <= 16'h0000;
            r_faStb <= 16'h0000;
            r_fbStb <= 16'h0000;
            r_wrap  <= 1'b0;
        end else if (w_rise) begin
            r_cnt   <= w_cntNext;
            r_faStb <= w_cntNext & ~r_cnt;
            r_fbStb <= r_cnt & ~w_cntNext;
            r_wrap  <= (r_cnt == 16'hFFFF);
        end else begin
            r_faStb <= 16'h0000;
            r_fbStb <= 16'h0000;
            r_wrap  <= 1'b0;
        end
    end

    assign FS     = r_cnt;
    assign FA_STB = r_faStb;
    assign FB_STB = r_fbStb;
    assign WRAP   = r_wrap;

`ifdef SCALER_FAIL_DETECT_EN
    localparam logic [15:0] LimitVal = 16'(STALL_LIMIT);

    logic [15:0] r_idle;

    // Idle watchdog: counts cycles since the last FS01 rising edge and
    // parks at the limit, so the alarm stays up until FS01 moves again.
    // SCLR deliberately has no effect here.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_idle <= 16'h0000;
        end else if (w_rise) begin
            r_idle <= 16'h0000;
        end else if (r_idle != LimitVal) begin
            r_idle <= r_idle + 16'd1;
        end
    end

    assign SCAFAL = (r_idle == LimitVal);
`else
    logic [15:0] w_unusedStallLimit;

    assign w_unusedStallLimit = 16'(STALL_LIMIT);
    assign SCAFAL             = 1'b0;
`endif

endmodule

// File: doc/agc_scaler.md
AGC_SCALER -- requirements
Module: agc_scaler

Interface
REQ-001 Parameter STALL_LIMIT, default 64: number of SIM_CLK cycles with no FS01 rising edge before a scaler failure is flagged; legal range 2..65535.
REQ-002 SIM_CLK  input  1  single system clock; all state changes on its rising edge.
REQ-003 SIM_RST  input  1  asynchronous, active-low reset.
REQ-004 FS01  input  1  first scaler stage produced by the timer, synchronous to SIM_CLK.
REQ-005 SCLR  input  1  synchronous scaler clear (test/maintenance), active-high.
REQ-006 FS  output  16  scaler stages FS02..FS17; FS[0] is FS02 and FS[15] is FS17.
REQ-007 FA_STB  output  16  one-cycle strobe per stage, asserted when that stage rises (F-pulse A).
REQ-008 FB_STB  output  16  one-cycle strobe per stage, asserted when that stage falls (F-pulse B).
REQ-009 WRAP  output  1  one-cycle strobe when the counter rolls from 0xFFFF to 0x0000.
REQ-010 SCAFAL  output  1  scaler failure alarm, level.

Function
REQ-011 The block registers FS01 into fs01_q every cycle; a rising edge is defined as FS01=1 while fs01_q=0.
REQ-012 On each rising edge, the 16-bit counter cnt increments by 1, modulo 2^16; FS equals cnt.
REQ-013 The new FS value is visible in the cycle after the edge is detected (latency 1 cycle); FS changes at most once per FS01 edge.
REQ-014 In the cycle FS takes its new value, FA_STB[i]=1 exactly for bits that went 0->1 and FB_STB[i]=1 exactly for bits that went 1->0; otherwise strobes are 0.
REQ-015 Wrap-around at 0xFFFF->0x0000 asserts WRAP and all 16 FB_STB bits for one cycle, with FA_STB all 0.
REQ-016 SCLR=1 loads cnt=0 on the next edge, overrides a simultaneous FS01 edge, and forces all strobes and WRAP to 0 for that update.
REQ-017 SCLR does not affect fs01_q or the stall watchdog.
REQ-018 Watchdog idle counter increments each cycle with no FS01 rising edge, saturating at STALL_LIMIT, and clears to 0 on a rising edge.
REQ-019 SCAFAL=1 while the idle counter equals STALL_LIMIT; SCAFAL drops to 0 in the cycle after the first subsequent FS01 rising edge.
REQ-020 FS01 held constant (high or low) counts as no edge; the counter is held.

Reset
REQ-021 SIM_RST=0 asynchronously forces cnt=0, FS=0, FA_STB=0, FB_STB=0, WRAP=0, idle counter=0, SCAFAL=0, fs01_q=1.
REQ-022 With fs01_q reset to 1, FS01 high at reset release produces no edge; the first count requires FS01 to go low and then high.
REQ-023 Reset asserted mid-count discards all state; no strobe is emitted on reset entry or exit.

Configuration
REQ-024 Macro SCALER_FAIL_DETECT_EN defined: the watchdog and SCAFAL operate per REQ-018..REQ-019.
REQ-025 SCALER_FAIL_DETECT_EN undefined: no idle counter is built, SCAFAL is tied to 0, STALL_LIMIT is ignored, and all other behaviour is unchanged.

Verification
REQ-026 Reset release with FS01=1, then 3 FS01 low/high pulses: FS=0x0003; FA_STB[0] pulses on counts 1 and 3; FA_STB[1] pulses on count 2.
REQ-027 Preload to 0xFFFE via pulses (or SCLR, then 65534 edges), then 2 edges: FS=0xFFFF, then FS=0x0000 with WRAP=1 and FB_STB=0xFFFF for exactly one cycle.
REQ-028 SCLR=1 in the same cycle as an FS01 edge at FS=0x0005: next FS=0x0000, all strobes 0, idle counter reset by the edge.
REQ-029 STALL_LIMIT=8 with macro defined, FS01 held low 8 cycles: SCAFAL rises on cycle 8, then falls one cycle after the next FS01 edge. With the macro undefined, SCAFAL stays 0.
REQ-030 SIM_RST pulsed low at FS=0x1234 between clock edges: FS=0 immediately with no strobe. After release, counting resumes from 0 on the first true rising edge.
